pipe_control: RTL and testbench

PIPE_CONTROL -- requirements
Module: pipe_control

---
 rtl/pipe_control_pkg.sv | 36 +++
 rtl/pipe_hazard_detect.sv | 26 ++
 rtl/pipe_control.sv | 162 ++++++++++++++++
 tb/tb_pipe_control.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_control_pkg.sv
// Shared constants for the pipeline controller: instruction codes, register IDs,
// status codes and the controller FSM state type.
package pipe_control_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RNONE    = 4'hF;

  localparam logic [3:0] STAT_AOK = 4'h1;
  localparam logic [3:0] STAT_ADR = 4'h2;
  localparam logic [3:0] STAT_INS = 4'h4;
  localparam logic [3:0] STAT_HLT = 4'h8;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  // Anything other than AOK is an exception, including undefined encodings.
  function automatic logic is_exc(input logic [3:0] stat);
    return (stat != STAT_AOK);
  endfunction

endpackage

// File: rtl/pipe_hazard_detect.sv
// Combinational pipeline hazard detection: load/use, return and branch mispredict.
module pipe_hazard_detect
  import pipe_control_pkg::*;
(
  input  logic [3:0] i_d_icode,
  input  logic [3:0] i_e_icode,
  input  logic [3:0] i_m_icode,
  input  logic [3:0] i_d_srca,
  input  logic [3:0] i_d_srcb,
  input  logic [3:0] i_e_dstm,
  input  logic       i_e_cnd,
  output logic       o_load_use,
  output logic       o_ret_hz,
  output logic       o_mispredict
);

  logic w_e_is_load;

  assign w_e_is_load  = (i_e_icode == I_MRMOVQ) || (i_e_icode == I_POPQ);
  assign o_load_use   = w_e_is_load && (i_e_dstm != RNONE) &&
                        ((i_e_dstm == i_d_srca) || (i_e_dstm == i_d_srcb));
  assign o_ret_hz     = (i_d_icode == I_RET) || (i_e_icode == I_RET) ||
                        (i_m_icode == I_RET);
  assign o_mispredict = (i_e_icode == I_JXX) && !i_e_cnd;

endmodule

// File: rtl/pipe_control.sv
// Pipeline stall/bubble controller with RUN/DRAIN/HALTED exception FSM.
// Optional saturating performance counters are enabled by defining PIPE_PERF_CNT_EN.
module pipe_control
  import pipe_control_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       m_stat,
  input  logic [3:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             halted,
  output logic [1:0]       state
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
`endif
);

  state_e r_state;
  state_e w_next;
  logic   r_halted;
  logic   w_load_use;
  logic   w_ret_hz;
  logic   w_mispredict;
  logic   w_m_exc;
  logic   w_w_exc;

  pipe_hazard_detect u_hazard (
    .i_d_icode    (D_icode),
    .i_e_icode    (E_icode),
    .i_m_icode    (M_icode),
    .i_d_srca     (d_srcA),
    .i_d_srcb     (d_srcB),
    .i_e_dstm     (E_dstM),
    .i_e_cnd      (e_Cnd),
    .o_load_use   (w_load_use),
    .o_ret_hz     (w_ret_hz),
    .o_mispredict (w_mispredict)
  );

  assign w_m_exc = is_exc(m_stat);
  assign w_w_exc = is_exc(W_stat);
  assign state   = r_state;
  assign halted  = r_halted;

  // Next-state selection; a writeback exception outranks a memory-stage one.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_w_exc) begin
          w_next = ST_HALTED;
        end else if (w_m_exc) begin
          w_next = ST_DRAIN;
        end else begin
          w_next = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (w_w_exc) begin
          w_next = ST_HALTED;
        end else begin
          w_next = ST_DRAIN;
        end
      end
      ST_HALTED: w_next = ST_HALTED;
      default:   w_next = ST_RUN;
    endcase
  end

  // Stall/bubble decode; the unused encoding behaves like RUN until it is cleared.
  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = w_m_exc || w_w_exc;
    W_stall  = w_w_exc;
    case (r_state)
      ST_DRAIN: begin
        F_stall  = 1'b1;
        D_bubble = 1'b1;
        E_bubble = 1'b1;
      end
      ST_HALTED: begin
        F_stall = 1'b1;
        D_stall = 1'b1;
        W_stall = 1'b1;
      end
      default: begin
        F_stall  = w_load_use || w_ret_hz;
        D_stall  = w_load_use;
        D_bubble = w_mispredict || (w_ret_hz && !w_load_use);
        E_bubble = w_mispredict || w_load_use;
      end
    endcase
  end

  // State register and registered halted flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_RUN;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_halted <= (w_next == ST_HALTED);
    end
  end

`ifdef PIPE_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;
  logic [CNT_W-1:0] r_mispredict_cnt;

  // Saturating event counters, frozen once the pipeline has halted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt      <= {CNT_W{1'b0}};
      r_bubble_cnt     <= {CNT_W{1'b0}};
      r_mispredict_cnt <= {CNT_W{1'b0}};
    end else if (r_state != ST_HALTED) begin
      if (F_stall && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
      if ((D_bubble || E_bubble) && (r_bubble_cnt != CNT_MAX)) begin
        r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
      end
      if (w_mispredict && (r_state == ST_RUN) && (r_mispredict_cnt != CNT_MAX)) begin
        r_mispredict_cnt <= r_mispredict_cnt + CNT_ONE;
      end
    end else begin
      r_stall_cnt      <= r_stall_cnt;
      r_bubble_cnt     <= r_bubble_cnt;
      r_mispredict_cnt <= r_mispredict_cnt;
    end
  end

  assign stall_cnt      = r_stall_cnt;
  assign bubble_cnt     = r_bubble_cnt;
  assign mispredict_cnt = r_mispredict_cnt;
`endif

endmodule

// File: tb/tb_pipe_control.sv
// Directed self-checking bench for pipe_control; counter checks apply when
// PIPE_PERF_CNT_EN is defined (counters are 4 bits here to reach saturation).
module tb_pipe_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] D_icode, E_icode, M_icode, d_srcA, d_srcB, E_dstM, m_stat, W_stat;
  logic       e_Cnd;
  logic       F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted;
  logic [1:0] state;
  logic [5:0] ctl;
  int         errors = 0;
  int         checks = 0;
`ifdef PIPE_PERF_CNT_EN
  logic [3:0] stall_cnt, bubble_cnt, mispredict_cnt;
`endif

  pipe_control #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
    .m_stat(m_stat), .W_stat(W_stat), .F_stall(F_stall), .D_stall(D_stall),
    .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
    .halted(halted), .state(state)
`ifdef PIPE_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .mispredict_cnt(mispredict_cnt)
`endif
  );

  always #5 clk = ~clk;

  // {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}
  assign ctl = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall};

  task automatic set_idle();
    D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1;
    d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF; e_Cnd = 1'b1;
    m_stat = 4'h1; W_stat = 4'h1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", halted); end
    checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL reset_ctl got %b exp 000000", ctl); end
`ifdef PIPE_PERF_CNT_EN
    checks++; if ({stall_cnt, bubble_cnt, mispredict_cnt} !== 12'h000) begin errors++;
      $display("FAIL reset_cnt got %h exp 000", {stall_cnt, bubble_cnt, mispredict_cnt}); end
`endif
  endtask

  task automatic test_load_use();
    do_reset();
    E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3; #1;
    checks++; if (ctl !== 6'b110100) begin errors++; $display("FAIL load_use_srcA got %b exp 110100", ctl); end
    E_icode = 4'hB; E_dstM = 4'h4; d_srcA = 4'hF; d_srcB = 4'h4; #1;
    checks++; if (ctl !== 6'b110100) begin errors++; $display("FAIL load_use_popq_srcB got %b exp 110100", ctl); end
    E_icode = 4'h5; E_dstM = 4'hF; d_srcA = 4'hF; d_srcB = 4'hF; #1;
    checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL load_use_rnone got %b exp 000000", ctl); end
    E_icode = 4'h6; E_dstM = 4'h3; d_srcA = 4'h3; #1;
    checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL load_use_not_load got %b exp 000000", ctl); end
  endtask

  task automatic test_mispredict();
    do_reset();
    E_icode = 4'h7; e_Cnd = 1'b1; D_icode = 4'h6; #1;
    checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL jxx_taken got %b exp 000000", ctl); end
    e_Cnd = 1'b0; #1;
    checks++; if (ctl !== 6'b001100) begin errors++; $display("FAIL mispredict got %b exp 001100", ctl); end
    tick();
    set_idle(); #1;
`ifdef PIPE_PERF_CNT_EN
    checks++; if (mispredict_cnt !== 4'd1) begin errors++; $display("FAIL mispredict_cnt got %0d exp 1", mispredict_cnt); end
    checks++; if (bubble_cnt !== 4'd1) begin errors++; $display("FAIL mp_bubble_cnt got %0d exp 1", bubble_cnt); end
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL mp_stall_cnt got %0d exp 0", stall_cnt); end
`endif
  endtask

  task automatic test_ret_drain();
    do_reset();
    D_icode = 4'h9; #1;
    checks++; if (ctl !== 6'b101000) begin errors++; $display("FAIL ret_D got %b exp 101000", ctl); end
    tick();
    D_icode = 4'h1; E_icode = 4'h9; #1;
    checks++; if (ctl !== 6'b101000) begin errors++; $display("FAIL ret_E got %b exp 101000", ctl); end
    tick();
    E_icode = 4'h1; M_icode = 4'h9; #1;
    checks++; if (ctl !== 6'b101000) begin errors++; $display("FAIL ret_M got %b exp 101000", ctl); end
    tick();
    set_idle(); #1;
    checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL ret_done got %b exp 000000", ctl); end
`ifdef PIPE_PERF_CNT_EN
    checks++; if (stall_cnt !== 4'd3) begin errors++; $display("FAIL ret_stall_cnt got %0d exp 3", stall_cnt); end
    checks++; if (bubble_cnt !== 4'd3) begin errors++; $display("FAIL ret_bubble_cnt got %0d exp 3", bubble_cnt); end
`endif
  endtask

  task automatic test_combo();
    do_reset();
    E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3; D_icode = 4'h9; #1;
    checks++; if (ctl !== 6'b110100) begin errors++; $display("FAIL combo_lu_ret got %b exp 110100", ctl); end
    set_idle(); E_icode = 4'h7; e_Cnd = 1'b0; D_icode = 4'h9; #1;
    checks++; if (ctl !== 6'b101100) begin errors++; $display("FAIL combo_mp_ret got %b exp 101100", ctl); end
    set_idle(); W_stat = 4'h2; #1;
    checks++; if (ctl !== 6'b000011) begin errors++; $display("FAIL wstat_run got %b exp 000011", ctl); end
    set_idle();
  endtask

  task automatic test_exception();
    do_reset();
    m_stat = 4'h4; #1;
    checks++; if (ctl !== 6'b000010) begin errors++; $display("FAIL exc_run got %b exp 000010", ctl); end
    tick();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL exc_to_drain got %0d exp 1", state); end
    checks++; if (ctl !== 6'b101110) begin errors++; $display("FAIL drain_ctl got %b exp 101110", ctl); end
    tick();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL drain_hold got %0d exp 1", state); end
    m_stat = 4'h1; W_stat = 4'h4; #1;
    checks++; if (ctl !== 6'b101111) begin errors++; $display("FAIL drain_wexc got %b exp 101111", ctl); end
    tick();
    checks++; if ({state, halted} !== 3'b101) begin errors++; $display("FAIL exc_halted got %b exp 101", {state, halted}); end
    checks++; if (ctl !== 6'b110011) begin errors++; $display("FAIL halted_ctl got %b exp 110011", ctl); end
    set_idle(); #1;
    checks++; if (ctl !== 6'b110001) begin errors++; $display("FAIL halted_idle got %b exp 110001", ctl); end
    tick(); tick();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL halted_hold got %0d exp 2", state); end
`ifdef PIPE_PERF_CNT_EN
    checks++; if ({stall_cnt, bubble_cnt} !== 8'h22) begin errors++;
      $display("FAIL halted_freeze got %h exp 22", {stall_cnt, bubble_cnt}); end
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({state, halted} !== 3'b000) begin errors++; $display("FAIL rst_halted got %b exp 000", {state, halted}); end
    checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL rst_halted_ctl got %b exp 000000", ctl); end
`ifdef PIPE_PERF_CNT_EN
    checks++; if ({stall_cnt, bubble_cnt, mispredict_cnt} !== 12'h000) begin errors++;
      $display("FAIL rst_halted_cnt got %h exp 000", {stall_cnt, bubble_cnt, mispredict_cnt}); end
`endif
    m_stat = 4'h2;
    tick();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL drain_again got %0d exp 1", state); end
    rst = 1'b1;
    tick();
    rst = 1'b0; set_idle(); #1;
    checks++; if ({state, halted, ctl} !== 9'b000_000000) begin errors++;
      $display("FAIL rst_drain got %b exp 000000000", {state, halted, ctl}); end
  endtask

  task automatic test_saturate();
    do_reset();
    D_icode = 4'h9;
    for (int i = 0; i < 20; i++) tick();
    set_idle(); #1;
`ifdef PIPE_PERF_CNT_EN
    checks++; if (stall_cnt !== 4'hF) begin errors++; $display("FAIL stall_sat got %0d exp 15", stall_cnt); end
    checks++; if (bubble_cnt !== 4'hF) begin errors++; $display("FAIL bubble_sat got %0d exp 15", bubble_cnt); end
`endif
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL sat_state got %0d exp 0", state); end
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    test_reset();
    test_load_use();
    test_mispredict();
    test_ret_drain();
    test_combo();
    test_exception();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
